// File: rtl/dmem_responder.sv
// dmem_responder: word data-memory responder with wait states, ready pulse and misalignment flag
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_next;
    logic [3:0] wait_cnt;
    logic lat_we;
    logic [ADDR_W+1:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic access, aligned;
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_W+2];
    assign idx = lat_addr[ADDR_W+1:2];
    assign aligned = lat_addr[1:0] == 2'b00;
    assign access = state == WAIT && wait_cnt == 4'd0;
    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_next;
    // next state: accept in IDLE, count down in WAIT, single RESP cycle
    always_comb
        state_next = state == IDLE ? (ce ? WAIT : IDLE) :
                     state == WAIT ? (wait_cnt == 4'd0 ? RESP : WAIT) : IDLE;
    // status outputs decoded from the state and the latched address
    always_comb begin
        ready = state == RESP;
        err   = state == RESP && !aligned;
        busy  = state != IDLE;
    end
    // request latch and wait-state counter
    always_ff @(posedge clk)
        if (rst)
            wait_cnt <= 4'd0;
        else if (state == IDLE && ce) begin
            wait_cnt  <= 4'(WAIT_CYCLES);
            lat_we    <= we;
            lat_addr  <= addr[ADDR_W+1:0];
            lat_wdata <= wdata;
        end else if (state == WAIT && wait_cnt != 4'd0)
            wait_cnt <= wait_cnt - 4'd1;
    // registered load data, updated only by completed aligned loads
    always_ff @(posedge clk)
        if (rst)
            rdata <= 32'd0;
        else if (access && aligned && !lat_we)
            rdata <= mem[idx];
    // RAM write; a reset at the commit edge abandons the store
    always_ff @(posedge clk)
        if (!rst && access && aligned && lat_we)
            mem[idx] <= lat_wdata;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder
module tb_dmem_responder;
    localparam int AW = 10;
    localparam int W  = 1;
    logic clk = 0;
    logic rst, ce, we, ready, err, busy;
    logic [31:0] addr, wdata, rdata;

    dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t q[$];
    logic [31:0] model_mem [int];
    logic [31:0] model_rdata;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a % (32'd4 << AW)) / 32'd4);
    endfunction

    // reference model: word memory indexed by byte address modulo RAM size
    function automatic void predict(input logic w, input logic [31:0] a, input logic [31:0] d, input int due);
        exp_t e;
        logic [31:0] aa;
        aa = a;
        e.err = aa[1:0] != 2'b00;
        if (!e.err) begin
            if (w) model_mem[word_of(aa)] = d;
            else model_rdata = model_mem[word_of(aa)];
        end
        e.rdata = model_rdata;
        e.due = due;
        q.push_back(e);
    endfunction

    // monitor: every ready pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 expected no response (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("resp_rdata", rdata, e.rdata);
                check("resp_err", {31'd0, err}, {31'd0, e.err});
                check("resp_cycle", cyc, e.due);
            end
        end else
            check("err_idle", {31'd0, err}, 32'd0);
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready expected ready within 20 cycles");
        end
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ce = 1; we = w; addr = a; wdata = d;
        predict(w, a, d, cyc + W + 2);
        @(negedge clk);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_ready();
        ce = 0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
    endtask

    initial begin
        logic [31:0] a;
        int k;
        rst = 1; ce = 1'($urandom); we = 1'($urandom); addr = $urandom; wdata = $urandom;
        repeat (2) begin
            @(negedge clk);
            check("rst_ready", {31'd0, ready}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_err", {31'd0, err}, 32'd0);
            check("rst_rdata", rdata, 32'd0);
            ce = 1'($urandom); we = 1'($urandom); addr = $urandom; wdata = $urandom;
        end
        rst = 0; ce = 0;
        model_rdata = 0;
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_rdata", rdata, 32'd0);
        for (int i = 0; i < 16; i++) access(1, 32'(i * 4), $urandom);
        access(1, 32'h0000_0010, 32'hDEAD_BEEF);
        access(0, 32'h0000_0010, 32'h0);
        access(1, 32'h0000_0012, 32'h1234_5678);
        access(0, 32'h0000_0010, 32'h0);
        @(negedge clk);
        ce = 1; we = 1; addr = 32'h20; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        rst = 1; ce = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        model_rdata = 0;
        check("rdata_after_abort", rdata, 32'd0);
        access(0, 32'h0000_0020, 32'h0);
        access(1, 32'h0000_1004, 32'hA5A5_A5A5);
        access(0, 32'h0000_0004, 32'h0);
        repeat (5) begin
            @(negedge clk);
            check("rdata_hold", rdata, 32'hA5A5_A5A5);
        end
        @(negedge clk);
        ce = 1; we = 0; addr = 32'h4; wdata = $urandom;
        k = cyc;
        predict(0, 32'h4, 32'h0, k + W + 2);
        predict(0, 32'h4, 32'h0, k + 2 * W + 5);
        repeat (8) @(negedge clk);
        ce = 0;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            access(1'($urandom), a, $urandom);
        end
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far side of the pipeline's MEM-stage memory port. It accepts word load/store requests presented on the ce/we/addr/wdata lines, applies a configurable number of wait states, and performs the access on a synchronous word RAM. It returns read data with a one-cycle `ready` pulse that the MEM stage and hazard logic use to release the pipeline stall. Misaligned requests are flagged instead of being executed.

## Interface
- `ADDR_W`, 10: word-address width; RAM holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 1: extra wait states per access; legal range 0..15.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ce`  in  1  request strobe; the requester holds it until it sees `ready`.
- `we`  in  1  1 = store (write), 0 = load (read); sampled with `ce`.
- `addr`  in  32  byte address; bits [1:0] must be 0.
- `wdata`  in  32  store data; sampled with `ce`.
- `rdata`  out  32  load data; valid while `ready`=1, then held.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  misalignment flag; valid only with `ready`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states:
  - **IDLE**: if `ce`=1 at a rising edge, latch `we`, `addr`, `wdata`, load `wait_cnt` = WAIT_CYCLES, then go to WAIT. Otherwise stay in IDLE.
  - **WAIT**: if `wait_cnt` = 0, perform the access at this edge and go to RESP. Otherwise decrement `wait_cnt`.
  - **RESP**: `ready`=1 for exactly this cycle, then go to IDLE unconditionally.
- Requests are accepted only in IDLE. `ce`, `we`, `addr` and `wdata` changes during WAIT or RESP are ignored.
- Word index is `addr[ADDR_W+1:2]`. `addr[31:ADDR_W+2]` is ignored, so addresses alias modulo 2^(ADDR_W+2) bytes.
- Access at the WAIT→RESP edge:
  - Store: `mem[idx]` ← latched `wdata`.
  - Load: `rdata` ← `mem[idx]`, registered.
- Misaligned request (latched `addr[1:0]` ≠ 0):
  - No RAM read or write is performed.
  - `err`=1 during RESP.
  - `rdata` keeps its previous value.
  - Latency is unchanged.
- On any aligned access, `err`=0 during RESP. `err` is 0 in every non-RESP cycle.
- `rdata` changes only on a completed aligned load or on reset. It holds its value across stores and idle cycles.
- `ce` still high in the IDLE cycle after RESP is treated as a new request. The requester must deassert `ce` after seeing `ready` unless it issues another access.

## Timing
- Reset values, applied at the rising edge with `rst`=1:
  - state = IDLE, `ready`=0, `err`=0, `busy`=0, `rdata`=0, `wait_cnt`=0.
  - RAM contents are not cleared.
- `rst` has priority over everything. A reset during WAIT abandons the access: no store is committed and no `ready` is produced. A reset during RESP leaves an already-committed store intact, and `ready` drops the next cycle.
- Latency: `ce` sampled at the end of cycle 0 gives WAIT for WAIT_CYCLES+1 cycles and RESP (`ready`=1) in cycle WAIT_CYCLES+2.
- Throughput: one access per WAIT_CYCLES+3 cycles, because of the mandatory IDLE cycle after RESP.
- `busy` goes high the cycle after acceptance and low the cycle after RESP.
- A load issued immediately after a store to the same index returns the stored data, since the store is committed before the load is accepted.

## Test plan
- Reset: hold `rst` 2 cycles while driving random inputs. Required: `ready`=0, `err`=0, `busy`=0, `rdata`=0 throughout and in the first cycle after release.
- Store then load, WAIT_CYCLES=1: store `addr`=0x0000_0010, `wdata`=0xDEAD_BEEF, then load 0x10. Required:
  - Each `ready` pulse occurs 3 cycles after `ce` is sampled.
  - Load `rdata`=0xDEAD_BEEF with `err`=0.
- Misaligned: store `addr`=0x12, `wdata`=0x1234_5678, then load 0x10. Required:
  - The misaligned access produces `ready`=1 with `err`=1.
  - The load still returns 0xDEAD_BEEF.
- Reset mid-access: store 0xCAFE_F00D to 0x20 and assert `rst` during WAIT. After release, load 0x20. Required:
  - No `ready` for the aborted store.
  - The load returns the prior contents of 0x20.
- Aliasing and hold, ADDR_W=10: store 0xA5A5_A5A5 to 0x0000_1004, then load 0x0000_0004. Required: `rdata`=0xA5A5_A5A5, and it stays there through 5 idle cycles.
- `ce` held high, WAIT_CYCLES=0: keep `ce` high with load 0x4 for 8 cycles. Required: `ready` pulses in cycles 2 and 5, with one-cycle pulses and an IDLE gap between them.
